// File: rtl/phase_transition_sequencer.sv
// Phase transition sequencer: turns the upstream one-hot green grant into
// four lamp codes, inserting a timed amber and an all-red clearance phase
// whenever the granted direction changes. Invalid grants force all-red.
//
// state  | meaning
// -------+---------------------------------------------------------------
// ALLRED | clearance; every lamp red; waits CLEAR_TICKS, then for a valid grant
// GREEN  | lamp of cur is green; left as soon as grant differs from cur
// AMBER  | lamp of cur is amber for AMBER_TICKS; grant ignored meanwhile

module phase_transition_sequencer #(
  parameter int unsigned AMBER_TICKS = 3,
  parameter int unsigned CLEAR_TICKS = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] grant,
  output logic [1:0] out0,
  output logic [1:0] out1,
  output logic [1:0] out2,
  output logic [1:0] out3,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_AMBER  = 2'd2
  } state_t;

  localparam logic [1:0] LAMP_GRN = 2'b01;
  localparam logic [1:0] LAMP_AMB = 2'b11;
  localparam logic [1:0] LAMP_RED = 2'b10;

  localparam logic [CNT_W-1:0] AMBER_LOAD = CNT_W'(AMBER_TICKS);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cur_q, cur_d;
  logic [1:0]       out0_q, out0_d;
  logic [1:0]       out1_q, out1_d;
  logic [1:0]       out2_q, out2_d;
  logic [1:0]       out3_q, out3_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;

  logic             grant_onehot;
  logic             cnt_expire;
  logic [1:0]       lit_code;

  // Grant validity and phase expiry qualifiers.
  always_comb begin
    grant_onehot = (grant != 4'b0000) && ((grant & (grant - 4'd1)) == 4'b0000);
    cnt_expire   = tick && (cnt_q == CNT_ONE);
  end

  // Next-state logic: phase sequencing and the phase down-counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    case (state_q)
      ST_ALLRED: begin
        // cnt==0 marks "clearance already served, waiting for a valid
        // grant"; in that case the grant is re-checked every clock.
        if (cnt_q == CNT_ZERO || cnt_expire) begin
          if (grant_onehot) begin
            state_d = ST_GREEN;
            cur_d   = grant;
          end else begin
            cnt_d = CNT_ZERO;
          end
        end else if (tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_GREEN: begin
        // Any deviation from the held grant, valid or not, ends green.
        // A tick on this clock is absorbed by the fresh amber load.
        if (grant != cur_q) begin
          state_d = ST_AMBER;
          cnt_d   = AMBER_LOAD;
        end
      end
      ST_AMBER: begin
        if (cnt_expire) begin
          state_d = ST_ALLRED;
          cnt_d   = CLEAR_LOAD;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_ALLRED;
        cnt_d   = CLEAR_LOAD;
        cur_d   = 4'b0000;
      end
    endcase
  end

  // Output decode from the next state so lamps register alongside the state.
  // Grant bit2 is south (out3) and bit3 is north (out2).
  always_comb begin
    out0_d   = LAMP_RED;
    out1_d   = LAMP_RED;
    out2_d   = LAMP_RED;
    out3_d   = LAMP_RED;
    lit_code = LAMP_RED;
    if (state_d == ST_GREEN) begin
      lit_code = LAMP_GRN;
    end else if (state_d == ST_AMBER) begin
      lit_code = LAMP_AMB;
    end
    if (cur_d[0]) out0_d = lit_code;
    if (cur_d[1]) out1_d = lit_code;
    if (cur_d[3]) out2_d = lit_code;
    if (cur_d[2]) out3_d = lit_code;
    busy_d  = (state_d != ST_GREEN);
    fault_d = !grant_onehot;
  end

  // State, counter and registered outputs; reset forces a safe all-red.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ALLRED;
      cnt_q   <= CLEAR_LOAD;
      cur_q   <= 4'b0000;
      out0_q  <= LAMP_RED;
      out1_q  <= LAMP_RED;
      out2_q  <= LAMP_RED;
      out3_q  <= LAMP_RED;
      busy_q  <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      out3_q  <= out3_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign out0  = out0_q;
  assign out1  = out1_q;
  assign out2  = out2_q;
  assign out3  = out3_q;
  assign busy  = busy_q;
  assign fault = fault_q;

endmodule
